// File: rtl/tetromino_bag_scheduler.sv
// Tetromino 7-bag scheduler.
// Filters the raw 3-bit PRBS stream into a fair 7-bag sequence: every piece 0..6 is issued
// once per bag, while value 7 and repeats inside the current bag are rejected. Accepted pieces
// go into a small shift queue (head = current piece, the rest = preview). The game FSM pops the
// head through a valid/ready handshake.
//
// Ports:
//   i_pixclk       system clock, rising edge
//   i_reset        synchronous active-high reset, highest priority
//   i_enable       level; allows the scheduler to fill the queue
//   i_new_game     one-cycle pulse; flush queue, bag and reject counter
//   i_rand         PRBS sample, one per cycle
//   i_piece_ready  consumer ready; pop on o_piece_valid && i_piece_ready
//   o_piece_valid  queue non-empty
//   o_piece_id     head-of-queue piece id (0 while empty)
//   o_bram_addr    o_piece_id << BASE_SHIFT, resized to ADDR_W
//   o_preview_ids  entries 1..QUEUE_DEPTH-1, 3 bits each, invalid slots read 3'd7
//   o_count        number of valid queue entries
//   o_bag_mask     bit p set = piece p already issued in the current bag
module tetromino_bag_scheduler #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned MAX_REJECT  = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_SHIFT  = 5
) (
  input  logic                         i_pixclk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_new_game,
  input  logic [2:0]                   i_rand,
  input  logic                         i_piece_ready,
  output logic                         o_piece_valid,
  output logic [2:0]                   o_piece_id,
  output logic [ADDR_W-1:0]            o_bram_addr,
  output logic [3*(QUEUE_DEPTH-1)-1:0] o_preview_ids,
  output logic [3:0]                   o_count,
  output logic [6:0]                   o_bag_mask
);

  localparam int unsigned RejW      = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
  localparam int unsigned AddrWideW = ADDR_W + BASE_SHIFT + 3;
  localparam logic [3:0]      Depth   = 4'(QUEUE_DEPTH);
  localparam logic [RejW-1:0] RejLast = RejW'(MAX_REJECT - 1);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e          state_q, state_d;
  logic [2:0]      queue_q [QUEUE_DEPTH];
  logic [2:0]      queue_d [QUEUE_DEPTH];
  logic [3:0]      count_q, count_d;
  logic [6:0]      mask_q, mask_d;
  logic [RejW-1:0] rej_q, rej_d;

  logic       pop, sample_en, accept, fallback, push;
  logic [2:0] fill_id, push_id;
  logic [3:0] count_after_pop;
  logic [7:0] mask_ext;
  logic [6:0] mask_set;

  // Lowest-index piece not yet issued; the mask never holds 7'h7F, so one always exists.
  always_comb begin
    fill_id = 3'd0;
    for (int p = 6; p >= 0; p--) begin
      if (!mask_q[p]) fill_id = 3'(p);
    end
  end

  always_comb begin
    pop       = (count_q != 4'd0) && i_piece_ready;
    // In StFull the queue is full, so sampling there only happens on a pop cycle.
    sample_en = ((state_q == StFill) || (state_q == StFull)) && (pop || (count_q < Depth));
    // Bit 7 forced high so that i_rand == 7 is never accepted.
    mask_ext  = {1'b1, mask_q};
    accept    = !mask_ext[i_rand];
    fallback  = !accept && (rej_q == RejLast);
    push      = sample_en && (accept || fallback);
    push_id   = accept ? i_rand : fill_id;
    mask_set  = mask_q | (7'b1 << push_id);
  end

  always_comb begin
    state_d         = state_q;
    queue_d         = queue_q;
    count_d         = count_q;
    mask_d          = mask_q;
    rej_d           = rej_q;
    count_after_pop = count_q - {3'b000, pop};

    if (i_new_game) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) queue_d[i] = 3'd7;
      count_d = 4'd0;
      mask_d  = 7'd0;
      rej_d   = '0;
      state_d = i_enable ? StFill : StIdle;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) queue_d[i] = queue_q[i+1];
        queue_d[QUEUE_DEPTH-1] = 3'd7;
      end

      if (sample_en) begin
        if (push) begin
          // Tail slot after the (optional) shift.
          for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            if (4'(i) == count_after_pop) queue_d[i] = push_id;
          end
          // Completing the bag starts the next one immediately.
          mask_d = (mask_set == 7'h7F) ? 7'd0 : mask_set;
          rej_d  = '0;
        end else begin
          rej_d = rej_q + RejW'(1);
        end
      end

      count_d = count_after_pop + {3'b000, push};

      unique case (state_q)
        StIdle: if (i_enable) state_d = StFill;
        StFill: begin
          if (!i_enable) state_d = StIdle;
          else if ((count_d == Depth) && !pop) state_d = StFull;
        end
        StFull: begin
          if (!i_enable) state_d = StIdle;
          else if (pop) state_d = StFill;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) queue_q[i] <= 3'd7;
      count_q <= 4'd0;
      mask_q  <= 7'd0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      queue_q <= queue_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    o_piece_valid = (count_q != 4'd0);
    o_count       = count_q;
    o_bag_mask    = mask_q;
    o_piece_id    = o_piece_valid ? queue_q[0] : 3'd0;
    o_bram_addr   = ADDR_W'(AddrWideW'(o_piece_id) << BASE_SHIFT);
    o_preview_ids = '1;
    for (int k = 1; k < int'(QUEUE_DEPTH); k++) begin
      o_preview_ids[3*(k-1) +: 3] = (4'(k) < count_q) ? queue_q[k] : 3'd7;
    end
  end

endmodule

// File: tb/tb_tetromino_bag_scheduler.sv
module tb_tetromino_bag_scheduler;

  localparam int D  = 4;
  localparam int MR = 4;
  localparam int AW = 8;
  localparam int BS = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            ng = 1'b0;
  logic [2:0]      rnd = 3'd7;
  logic            rdy = 1'b0;
  logic            valid;
  logic [2:0]      piece_id;
  logic [AW-1:0]   bram_addr;
  logic [3*(D-1)-1:0] preview;
  logic [3:0]      count;
  logic [6:0]      bag_mask;

  tetromino_bag_scheduler #(
    .QUEUE_DEPTH(D),
    .MAX_REJECT (MR),
    .ADDR_W     (AW),
    .BASE_SHIFT (BS)
  ) dut (
    .i_pixclk     (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_new_game   (ng),
    .i_rand       (rnd),
    .i_piece_ready(rdy),
    .o_piece_valid(valid),
    .o_piece_id   (piece_id),
    .o_bram_addr  (bram_addr),
    .o_preview_ids(preview),
    .o_count      (count),
    .o_bag_mask   (bag_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of pieces, set of issued pieces, reject run length,
  // and whether sampling is armed (enable seen at the previous edge).
  int mq[$];
  int exp_q[$];
  bit used[7];
  int rej = 0;
  bit armed = 0;
  bit model_ok = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int bag_bits();
    int b = 0;
    for (int p = 0; p < 7; p++) if (used[p]) b += (1 << p);
    return b;
  endfunction

  task automatic clear_bag();
    for (int p = 0; p < 7; p++) used[p] = 0;
  endtask

  task automatic model_step();
    int take;
    int all;
    if (rst) begin
      mq.delete(); clear_bag(); rej = 0; armed = 0;
    end else if (ng) begin
      mq.delete(); clear_bag(); rej = 0; armed = en;
    end else begin
      if (mq.size() > 0 && rdy) begin
        exp_q.push_back(mq.pop_front());
      end
      if (armed && mq.size() < D) begin
        take = -1;
        if (rnd != 3'd7 && !used[rnd]) begin
          take = int'(rnd);
        end else if (rej == MR - 1) begin
          for (int p = 6; p >= 0; p--) if (!used[p]) take = p;
        end else begin
          rej++;
        end
        if (take >= 0) begin
          rej = 0;
          mq.push_back(take);
          used[take] = 1;
          all = 1;
          for (int p = 0; p < 7; p++) if (!used[p]) all = 0;
          if (all == 1) clear_bag();
        end
      end
      armed = en;
    end
  endtask

  task automatic check_state();
    chk("count", int'(count), mq.size());
    chk("valid", int'(valid), (mq.size() > 0) ? 1 : 0);
    chk("bag_mask", int'(bag_mask), bag_bits());
    if (mq.size() > 0) chk("head", int'(piece_id), mq[0]);
    chk("bram_addr_consistent", int'(bram_addr), (int'(piece_id) << BS) & ((1 << AW) - 1));
    for (int k = 1; k < D; k++) begin
      chk("preview", int'(preview[3*(k-1) +: 3]), (k < mq.size()) ? mq[k] : 7);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit g, input int rv, input bit y);
    @(negedge clk);
    if (model_ok) check_state();
    rst = r; en = e; ng = g; rnd = 3'(rv); rdy = y;
    model_step();
    model_ok = 1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake the DUT accepts must match the next expected piece.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !ng && valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_id", int'(piece_id), e);
          chk("pop_addr", int'(bram_addr), (e << BS) & ((1 << AW) - 1));
        end
      end
    end
  end

  initial begin
    int lvl;
    // Reset held 3 cycles, then released with enable low.
    repeat (3) cycle(1, 0, 0, 7, 0);
    cycle(0, 0, 0, 7, 0);
    settle();
    chk("reset_valid", int'(valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_mask", int'(bag_mask), 0);
    chk("reset_preview", int'(preview), 'h1FF);
    chk("reset_addr", int'(bram_addr), 0);

    // Fill 0..3; fifth sample meets a full queue.
    cycle(0, 1, 0, 7, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, i, 0);
    settle();
    chk("fill_count", int'(count), 4);
    chk("fill_mask", int'(bag_mask), 'b0001111);
    chk("fill_addr", int'(bram_addr), 'h00);
    chk("fill_preview", int'(preview), (3 << 6) | (2 << 3) | 1);
    cycle(0, 0, 0, 0, 1);
    settle();
    chk("pop_head", int'(piece_id), 1);
    chk("pop_addr_1", int'(bram_addr), 'h20);

    // Rejects of 7 and repeats from an empty queue.
    cycle(0, 1, 1, 7, 0);
    cycle(0, 1, 0, 7, 0);
    cycle(0, 1, 0, 7, 0);
    cycle(0, 1, 0, 3, 0);
    cycle(0, 1, 0, 3, 0);
    cycle(0, 1, 0, 5, 0);
    settle();
    chk("reject_mask", int'(bag_mask), 'b0101000);
    chk("reject_count", int'(count), 2);

    // Forced fill and bag rollover.
    cycle(0, 1, 1, 7, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, i, 1);
    repeat (4) cycle(0, 1, 0, 7, 1);
    settle();
    chk("fallback_mask", int'(bag_mask), 0);
    chk("fallback_count", int'(count), 1);
    chk("fallback_piece", int'(piece_id), 6);

    // Pop and push in the same cycle.
    cycle(0, 1, 1, 7, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, i, 0);
    cycle(0, 1, 0, 3, 1);
    settle();
    chk("popush_count", int'(count), 3);
    chk("popush_head", int'(piece_id), 1);
    chk("popush_entry2", int'(preview[5:3]), 3);

    // New game while full.
    cycle(0, 1, 1, 7, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, i, 0);
    cycle(0, 1, 1, 4, 1);
    settle();
    chk("newgame_count", int'(count), 0);
    chk("newgame_mask", int'(bag_mask), 0);

    // Randomised traffic.
    lvl = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) lvl = $urandom_range(0, 4);
      cycle(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 79) == 0),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) < lvl));
    end

    cycle(0, 0, 0, 7, 0);
    @(negedge clk);
    check_state();
    #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
